// File: rtl/sramlike_arbiter_if.sv
// Sram-like bus bundle: request fields flow master -> slave, read data and the
// addr_ok/data_ok handshakes flow slave -> master.
interface sramlike_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );
endinterface

// File: rtl/sramlike_arbiter.sv
// Two-to-one sram-like arbiter: one owner per transaction, request fields forwarded
// from the owner, master handshakes routed back combinationally to the owner only.
module sramlike_arbiter #(
    parameter int unsigned DATA_PRIO = 1
) (
    input  logic               clk,
    input  logic               rst,
    sramlike_arbiter_if.slave  inst_if,
    sramlike_arbiter_if.slave  data_if,
    sramlike_arbiter_if.master m_if,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_I_ADDR = 3'd1,
        S_I_DATA = 3'd2,
        S_D_ADDR = 3'd3,
        S_D_DATA = 3'd4
    } state_e;

    localparam bit DATA_WINS_TIE = (DATA_PRIO != 0);

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   busy_q, busy_d;

    logic i_addr_ph, i_owner;
    logic d_addr_ph, d_owner;
    logic tie_to_data;

    assign i_addr_ph = (state_q == S_I_ADDR);
    assign d_addr_ph = (state_q == S_D_ADDR);
    assign i_owner   = i_addr_ph || (state_q == S_I_DATA);
    assign d_owner   = d_addr_ph || (state_q == S_D_DATA);

    // Round-robin serves the side that did not finish last; last_grant resets to 1.
    assign tie_to_data = DATA_WINS_TIE || !last_grant_q;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            S_IDLE: begin
                if (inst_if.req && data_if.req) begin
                    state_d = tie_to_data ? S_D_ADDR : S_I_ADDR;
                end else if (inst_if.req) begin
                    state_d = S_I_ADDR;
                end else if (data_if.req) begin
                    state_d = S_D_ADDR;
                end
            end
            S_I_ADDR: begin
                if (!inst_if.req) begin
                    state_d = S_IDLE;
                end else if (m_if.addr_ok && m_if.data_ok) begin
                    state_d      = S_IDLE;
                    last_grant_d = 1'b0;
                end else if (m_if.addr_ok) begin
                    state_d = S_I_DATA;
                end
            end
            S_I_DATA: begin
                if (m_if.data_ok) begin
                    state_d      = S_IDLE;
                    last_grant_d = 1'b0;
                end
            end
            S_D_ADDR: begin
                if (!data_if.req) begin
                    state_d = S_IDLE;
                end else if (m_if.addr_ok && m_if.data_ok) begin
                    state_d      = S_IDLE;
                    last_grant_d = 1'b1;
                end else if (m_if.addr_ok) begin
                    state_d = S_D_DATA;
                end
            end
            S_D_DATA: begin
                if (m_if.data_ok) begin
                    state_d      = S_IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
        end
    end

    assign busy = busy_q;

    // Owner fields are forwarded combinationally; IDLE drives an all-zero request.
    always_comb begin
        m_if.req   = (i_addr_ph && inst_if.req) || (d_addr_ph && data_if.req);
        m_if.wr    = 1'b0;
        m_if.size  = 2'd0;
        m_if.addr  = 32'd0;
        m_if.wdata = 32'd0;
        if (i_owner) begin
            m_if.wr    = inst_if.wr;
            m_if.size  = inst_if.size;
            m_if.addr  = inst_if.addr;
            m_if.wdata = inst_if.wdata;
        end else if (d_owner) begin
            m_if.wr    = data_if.wr;
            m_if.size  = data_if.size;
            m_if.addr  = data_if.addr;
            m_if.wdata = data_if.wdata;
        end
    end

    // A data_ok seen in IDLE has no owner and is dropped here.
    assign inst_if.addr_ok = m_if.addr_ok && i_addr_ph;
    assign inst_if.data_ok = m_if.data_ok && i_owner;
    assign data_if.addr_ok = m_if.addr_ok && d_addr_ph;
    assign data_if.data_ok = m_if.data_ok && d_owner;

    assign inst_if.rdata = m_if.rdata;
    assign data_if.rdata = m_if.rdata;

    a_one_addr_ok: assert property (@(posedge clk) disable iff (!rst)
        !(inst_if.addr_ok && data_if.addr_ok));
    a_one_data_ok: assert property (@(posedge clk) disable iff (!rst)
        !(inst_if.data_ok && data_if.data_ok));
    a_busy_decode: assert property (@(posedge clk) disable iff (!rst)
        busy_q == (state_q != S_IDLE));

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Scoreboard bench for sramlike_arbiter: directed stimulus pushes expected events,
// a negedge monitor pops and compares every grant and handshake the DUTs present.
module tb_sramlike_arbiter;

    typedef enum logic [3:0] {
        EV_GRANT = 4'd1,
        EV_IADDR = 4'd2,
        EV_IDATA = 4'd3,
        EV_DADDR = 4'd4,
        EV_DDATA = 4'd5
    } ev_kind_e;

    typedef struct {
        logic        u;
        ev_kind_e    kind;
        int          cyc;
        logic [31:0] val;
        logic [31:0] aux;
        logic [2:0]  ctl;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy0, busy1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    logic mreq_prev[2] = '{1'b0, 1'b0};

    sramlike_arbiter_if inst0_if();
    sramlike_arbiter_if data0_if();
    sramlike_arbiter_if m0_if();
    sramlike_arbiter_if inst1_if();
    sramlike_arbiter_if data1_if();
    sramlike_arbiter_if m1_if();

    sramlike_arbiter #(.DATA_PRIO(1)) dut_prio (
        .clk(clk), .rst(rst), .inst_if(inst0_if), .data_if(data0_if), .m_if(m0_if), .busy(busy0)
    );

    sramlike_arbiter #(.DATA_PRIO(0)) dut_rr (
        .clk(clk), .rst(rst), .inst_if(inst1_if), .data_if(data1_if), .m_if(m1_if), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] pack_ev(input ev_t e);
        return {39'd0, e.u, e.kind, e.cyc[15:0], 1'b0, e.ctl, e.val, e.aux};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic u, input ev_kind_e k, input int c, input logic [31:0] v,
                        input logic [31:0] a = 32'd0, input logic [2:0] ct = 3'd0);
        ev_t e;
        e.u = u; e.kind = k; e.cyc = c; e.val = v; e.aux = a; e.ctl = ct;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic u, input ev_kind_e k, input logic [31:0] v,
                           input logic [31:0] a, input logic [2:0] ct);
        ev_t o, e;
        o.u = u; o.kind = k; o.cyc = cyc; o.val = v; o.aux = a; o.ctl = ct;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s: got %h expected no event", k.name(), pack_ev(o));
        end else begin
            e = exp_q.pop_front();
            check($sformatf("sb_%s", e.kind.name()), pack_ev(o), pack_ev(e));
        end
    endtask

    task automatic flush_stale();
        ev_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_%s: got no event expected %h", e.kind.name(), pack_ev(e));
        end
    endtask

    always @(negedge clk) begin
        flush_stale();
        if (m0_if.req && !mreq_prev[0]) observe(1'b0, EV_GRANT, m0_if.addr, m0_if.wdata, {m0_if.wr, m0_if.size});
        if (inst0_if.addr_ok) observe(1'b0, EV_IADDR, 32'd0, 32'd0, 3'd0);
        if (inst0_if.data_ok) observe(1'b0, EV_IDATA, inst0_if.rdata, 32'd0, 3'd0);
        if (data0_if.addr_ok) observe(1'b0, EV_DADDR, 32'd0, 32'd0, 3'd0);
        if (data0_if.data_ok) observe(1'b0, EV_DDATA, data0_if.rdata, 32'd0, 3'd0);
        mreq_prev[0] = m0_if.req;
        if (m1_if.req && !mreq_prev[1]) observe(1'b1, EV_GRANT, m1_if.addr, m1_if.wdata, {m1_if.wr, m1_if.size});
        if (inst1_if.addr_ok) observe(1'b1, EV_IADDR, 32'd0, 32'd0, 3'd0);
        if (inst1_if.data_ok) observe(1'b1, EV_IDATA, inst1_if.rdata, 32'd0, 3'd0);
        if (data1_if.addr_ok) observe(1'b1, EV_DADDR, 32'd0, 32'd0, 3'd0);
        if (data1_if.data_ok) observe(1'b1, EV_DDATA, data1_if.rdata, 32'd0, 3'd0);
        mreq_prev[1] = m1_if.req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst0_if.req = 0; inst0_if.wr = 0; inst0_if.size = 0; inst0_if.addr = 0; inst0_if.wdata = 0;
        data0_if.req = 0; data0_if.wr = 0; data0_if.size = 0; data0_if.addr = 0; data0_if.wdata = 0;
        inst1_if.req = 0; inst1_if.wr = 0; inst1_if.size = 0; inst1_if.addr = 0; inst1_if.wdata = 0;
        data1_if.req = 0; data1_if.wr = 0; data1_if.size = 0; data1_if.addr = 0; data1_if.wdata = 0;
        m0_if.rdata = 0; m0_if.addr_ok = 0; m0_if.data_ok = 0;
        m1_if.rdata = 0; m1_if.addr_ok = 0; m1_if.data_ok = 0;
    endtask

    initial begin
        int t;
        clear_inputs();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        tick();
        check("reset_busy", busy0, 0);
        check("reset_mreq", m0_if.req, 0);

        // Single inst read: addr_ok at t+2, data_ok at t+4.
        t = cyc;
        inst0_if.req = 1; inst0_if.addr = 32'hBFC00000; inst0_if.size = 2;
        push(0, EV_GRANT, t + 1, 32'hBFC00000, 32'd0, 3'b010);
        push(0, EV_IADDR, t + 2, 32'd0);
        push(0, EV_IDATA, t + 4, 32'h3C1D0000);
        tick(); check("t1_busy_grant", busy0, 1);
        tick(); m0_if.addr_ok = 1; #1 check("t1_mreq_held", m0_if.req, 1);
        tick(); m0_if.addr_ok = 0; inst0_if.req = 0; #1 check("t1_mreq_data_phase", m0_if.req, 0);
        tick(); m0_if.data_ok = 1; m0_if.rdata = 32'h3C1D0000;
        tick(); m0_if.data_ok = 0; m0_if.rdata = 0;
        #1 check("t1_busy_idle", busy0, 0);
        check("t1_maddr_idle", m0_if.addr, 0);
        tick();

        // Simultaneous inst read and data write with data priority.
        t = cyc;
        inst0_if.req = 1; inst0_if.addr = 32'hBFC00010; inst0_if.size = 2;
        data0_if.req = 1; data0_if.wr = 1; data0_if.size = 2;
        data0_if.addr = 32'h80001000; data0_if.wdata = 32'h12345678;
        push(0, EV_GRANT, t + 1, 32'h80001000, 32'h12345678, 3'b110);
        push(0, EV_DADDR, t + 1, 32'd0);
        push(0, EV_DDATA, t + 2, 32'hDEADBEEF);
        push(0, EV_GRANT, t + 4, 32'hBFC00010, 32'd0, 3'b010);
        push(0, EV_IADDR, t + 4, 32'd0);
        push(0, EV_IDATA, t + 4, 32'hCAFEF00D);
        tick(); m0_if.addr_ok = 1;
        tick(); m0_if.addr_ok = 0; data0_if.req = 0; m0_if.data_ok = 1; m0_if.rdata = 32'hDEADBEEF;
        tick(); m0_if.data_ok = 0; m0_if.rdata = 0;
        #1 check("t2_idle_between_busy", busy0, 0);
        check("t2_idle_between_mreq", m0_if.req, 0);
        tick(); m0_if.addr_ok = 1; m0_if.data_ok = 1; m0_if.rdata = 32'hCAFEF00D;
        tick(); clear_inputs();
        #1 check("t2_busy_idle", busy0, 0);
        tick();

        // Same-cycle addr_ok and data_ok in D_ADDR.
        t = cyc;
        data0_if.req = 1; data0_if.addr = 32'h80002000; data0_if.size = 2;
        push(0, EV_GRANT, t + 1, 32'h80002000, 32'd0, 3'b010);
        push(0, EV_DADDR, t + 1, 32'd0);
        push(0, EV_DDATA, t + 1, 32'h11223344);
        tick(); m0_if.addr_ok = 1; m0_if.data_ok = 1; m0_if.rdata = 32'h11223344;
        tick(); clear_inputs();
        #1 check("t4_busy_next", busy0, 0);
        check("t4_mreq_next", m0_if.req, 0);
        tick();

        // Stray data_ok in IDLE.
        m0_if.data_ok = 1; m0_if.rdata = 32'h55AA55AA;
        #1 check("t6_stray_inst_data_ok", inst0_if.data_ok, 0);
        check("t6_stray_data_data_ok", data0_if.data_ok, 0);
        tick(); m0_if.data_ok = 0; m0_if.rdata = 0;
        #1 check("t6_stray_busy", busy0, 0);

        // Dropped inst request in I_ADDR.
        t = cyc;
        inst0_if.req = 1; inst0_if.addr = 32'hBFC00020; inst0_if.size = 2;
        push(0, EV_GRANT, t + 1, 32'hBFC00020, 32'd0, 3'b010);
        tick(); #1 check("t6_drop_mreq_granted", m0_if.req, 1);
        tick(); inst0_if.req = 0; #1 check("t6_drop_mreq_low", m0_if.req, 0);
        tick(); check("t6_drop_busy_idle", busy0, 0);
        clear_inputs();
        tick();

        // Reset asserted mid-transaction in I_DATA.
        t = cyc;
        inst0_if.req = 1; inst0_if.addr = 32'hBFC00030; inst0_if.size = 2;
        push(0, EV_GRANT, t + 1, 32'hBFC00030, 32'd0, 3'b010);
        push(0, EV_IADDR, t + 1, 32'd0);
        tick(); m0_if.addr_ok = 1;
        tick(); m0_if.addr_ok = 0; inst0_if.req = 0;
        #1 check("t5_busy_data_phase", busy0, 1);
        rst = 1'b0;
        m0_if.addr_ok = 1; m0_if.data_ok = 1; m0_if.rdata = 32'h0BADF00D;
        #1 check("t5_rst_busy", busy0, 0);
        check("t5_rst_mreq", m0_if.req, 0);
        check("t5_rst_inst_addr_ok", inst0_if.addr_ok, 0);
        check("t5_rst_inst_data_ok", inst0_if.data_ok, 0);
        check("t5_rst_data_data_ok", data0_if.data_ok, 0);
        check("t5_rst_inst_rdata", inst0_if.rdata, 32'h0BADF00D);
        check("t5_rst_data_rdata", data0_if.rdata, 32'h0BADF00D);
        tick();
        clear_inputs();
        tick();
        rst = 1'b1;
        tick();
        t = cyc;
        data0_if.req = 1; data0_if.addr = 32'h80003000; data0_if.size = 2;
        push(0, EV_GRANT, t + 1, 32'h80003000, 32'd0, 3'b010);
        push(0, EV_DADDR, t + 2, 32'd0);
        push(0, EV_DDATA, t + 3, 32'h99887766);
        tick();
        tick(); m0_if.addr_ok = 1;
        tick(); m0_if.addr_ok = 0; data0_if.req = 0; m0_if.data_ok = 1; m0_if.rdata = 32'h99887766;
        tick(); clear_inputs();
        #1 check("t5_after_busy", busy0, 0);
        tick();

        // Round-robin instance: both sides held, grants I, D, I, D.
        t = cyc;
        inst1_if.req = 1; inst1_if.addr = 32'hBFC00100; inst1_if.size = 2;
        data1_if.req = 1; data1_if.addr = 32'h80004000; data1_if.size = 2;
        for (int k = 0; k < 4; k++) begin
            int g;
            g = t + 1 + 2 * k;
            if (k % 2 == 0) begin
                push(1, EV_GRANT, g, 32'hBFC00100, 32'd0, 3'b010);
                push(1, EV_IADDR, g, 32'd0);
                push(1, EV_IDATA, g, 32'hA0000000 + k);
            end else begin
                push(1, EV_GRANT, g, 32'h80004000, 32'd0, 3'b010);
                push(1, EV_DADDR, g, 32'd0);
                push(1, EV_DDATA, g, 32'hA0000000 + k);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick(); m1_if.addr_ok = 1; m1_if.data_ok = 1; m1_if.rdata = 32'hA0000000 + k;
            tick(); m1_if.addr_ok = 0; m1_if.data_ok = 0; m1_if.rdata = 0;
        end
        clear_inputs();
        #1 check("t3_rr_busy_idle", busy1, 0);

        repeat (3) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sramlike_arbiter.md
# sramlike_arbiter

Two-to-one arbiter that shares a single sram-like master port (toward the AXI bridge) between the instruction-side and data-side sram-like interfaces produced by the CPU's sram-to-sram-like adapters. It grants one requester per transaction, forwards that requester's request fields, and routes the handshake responses back only to the owner. Only one transaction is outstanding at a time. Ownership holds from grant until the owner's `data_ok`.

## Interface
Parameters:
- `DATA_PRIO`, default 1. When 1, data side has strict priority on a tie. When 0, ties alternate (round-robin).

Ports:
- `clk` input 1. Single clock; all state updates on rising edge.
- `rst` input 1. Asynchronous, active-low reset.
- `inst_req`, `inst_wr` input 1. Instruction-side request and write flag.
- `inst_size` input 2. Instruction-side transfer size.
- `inst_addr`, `inst_wdata` input 32. Instruction-side address and write data.
- `inst_rdata` output 32. Read data returned to the instruction side.
- `inst_addr_ok`, `inst_data_ok` output 1. Instruction-side handshake responses.
- `data_req`, `data_wr` input 1. Data-side request and write flag.
- `data_size` input 2. Data-side transfer size.
- `data_addr`, `data_wdata` input 32. Data-side address and write data.
- `data_rdata` output 32. Read data returned to the data side.
- `data_addr_ok`, `data_data_ok` output 1. Data-side handshake responses.
- `m_req`, `m_wr` output 1. Master-side request and write flag.
- `m_size` output 2. Master-side transfer size.
- `m_addr`, `m_wdata` output 32. Master-side address and write data.
- `m_rdata` input 32. Master-side read data.
- `m_addr_ok`, `m_data_ok` input 1. Master-side handshake responses.
- `busy` output 1. High in any state other than IDLE.

## Operation
- FSM states: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA. One register `last_grant` records the side served last (0 = inst, 1 = data).
- IDLE transitions:
  - Only `inst_req` is high: go to I_ADDR.
  - Only `data_req` is high: go to D_ADDR.
  - Both are high and `DATA_PRIO=1`: go to D_ADDR.
  - Both are high and `DATA_PRIO=0`: serve the side not equal to `last_grant`.
  - Neither is high: stay in IDLE.
- X_ADDR (X = I or D) transitions:
  - `m_req` = owner's `req`.
  - Owner `req` low: return to IDLE with no transaction.
  - `m_addr_ok` & `m_data_ok`: go to IDLE, set `last_grant` = X.
  - `m_addr_ok` only: go to X_DATA.
  - Otherwise: hold.
- X_DATA transitions:
  - `m_req` = 0.
  - `m_data_ok`: go to IDLE, set `last_grant` = X.
  - A new request from either side is not sampled until IDLE.
- Master-side muxing:
  - `m_wr`, `m_size`, `m_addr`, `m_wdata` come from the owner in X_ADDR and X_DATA.
  - They are all 0 in IDLE.
- Slave-side responses:
  - `X_addr_ok` = `m_addr_ok` & (state == X_ADDR).
  - `X_data_ok` = `m_data_ok` & (state == X_ADDR or X_DATA).
  - The non-owner never sees `addr_ok` or `data_ok`.
  - `inst_rdata` = `data_rdata` = `m_rdata`, broadcast unregistered. Only the owner's `data_ok` qualifies it.
- `m_data_ok` arriving in IDLE is a protocol error. It is ignored: no `*_data_ok` is asserted and the state is unchanged.
- Reset (asynchronous, any state, including mid-transaction):
  - State goes to IDLE and `last_grant` goes to 1, so inst wins the first round-robin tie.
  - Outputs are 0 during reset: `m_req`, `m_wr`, `m_size`, `m_addr`, `m_wdata`, all `*_addr_ok`, all `*_data_ok`, `busy`.
  - `*_rdata` follows `m_rdata`.
  - An in-flight master transaction is abandoned.

## Timing
- Grant is registered. A request first seen in IDLE at cycle t drives `m_req` at t+1.
- Minimum transaction occupancy is 1 cycle in X_ADDR when `addr_ok` and `data_ok` arrive together. IDLE to the next grant costs 1 cycle, so back-to-back requests from one side issue every 2 cycles minimum.
- `m_req` is stable from grant until `m_addr_ok`, provided the owner holds `req`. Owner fields may not change during X_ADDR; they are forwarded combinationally.
- All response paths (`addr_ok`, `data_ok`, `rdata`) are combinational from the master port to the slave ports, with 0 added latency.
- `busy` is registered-state decode, glitch-free.

## Test plan
- **Single inst read.** Stimulus: `inst_req`=1 with `inst_addr`=0xBFC00000; `m_addr_ok` at t+2, `m_data_ok` at t+4 with `m_rdata`=0x3C1D0000. Required response:
  - `m_req` is high t+1..t+2 with `m_addr` 0xBFC00000.
  - `inst_addr_ok` pulses at t+2.
  - `inst_data_ok` pulses at t+4 with `inst_rdata`=0x3C1D0000.
  - `data_data_ok` stays 0 throughout.
- **Simultaneous requests, `DATA_PRIO=1`.** Stimulus: inst read and data write (`data_wr`=1, `data_size`=2, `data_wdata`=0x12345678) asserted in the same cycle. Required response: the data transaction is issued first; inst is granted in the IDLE cycle after `data_data_ok`.
- **Simultaneous requests, `DATA_PRIO=0`, held continuously.** Required response:
  - The first grant goes to inst (`last_grant` reset = 1).
  - Grants then alternate I, D, I, D over 4 transactions.
- **Same-cycle `addr_ok` and `data_ok`.**
  - Stimulus: in D_ADDR, both `m_addr_ok` and `m_data_ok` = 1.
  - Required response: `data_addr_ok` and `data_data_ok` pulse together, and the state returns to IDLE the next cycle.
- **Reset mid-transaction.** Stimulus: assert `rst`=0 during I_DATA. Required response:
  - `m_req`, `busy` and all `*_ok` outputs are 0 immediately, without waiting for a clock.
  - After release, a new data request is issued normally.
- **Stray `m_data_ok` and dropped request.**
  - Stray: pulse `m_data_ok` in IDLE. Required response: no `*_data_ok` asserted.
  - Dropped: `inst_req` drops in I_ADDR before `addr_ok`. Required response: the state returns to IDLE and `m_req` = 0 that cycle.
